matrix_scan_ctrl: RTL and testbench
===================================

// Module: matrix_scan_ctrl
// PURPOSE
//  Sequencer for the 5x7 LED matrix. It time-multiplexes the 7 column drivers and
//  produces the scroll strobes consumed by the row pattern registers.
//  Mode comes from the ch1/ch0 switches, latched once per frame.
//  It sits between the board switches/clock and the row registers plus the column driver pins.
// PARAMETERS
//  SCAN_DIV     4   clocks per column slot; legal range >= 2; slot cycle 0 is dead time
//  STEP_FRAMES  2   full frames per scroll/blink step; legal range >= 1
//  MSG_LEN      16  message length in columns; offset wraps modulo this; power of 2 >= 2
//  (localparam OW = clog2(MSG_LEN))
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  ch1, ch0     in   1   mode switches, asynchronous to clk
//  col_n        out  7   column enables, active-low one-hot; col_n[6] = column 0
//  col_idx      out  3   current column index 0..6
//  offset       out  OW  current scroll position, 0..MSG_LEN-1
//  shift_l      out  1   1-cycle strobe: row registers shift left one column
//  shift_r      out  1   1-cycle strobe: row registers shift right one column
//  frame_start  out  1   high in cycle 0 of the column-0 slot
//  mode         out  2   latched mode {ch1,ch0}
// BEHAVIOUR
//  - Reset values:
//    * col_n = 7'b1111111, col_idx = 0, offset = 0, mode = 2'b00;
//    * prescaler, frame counter, blink phase and synchroniser flops = 0;
//    * shift_l = shift_r = 0.
//    * Reset asserted mid-frame clears all state immediately; no strobe is emitted.
//  - Switch sync: 2-flop synchroniser on ch1/ch0, giving 2-cycle latency.
//  - Prescaler pc runs 0..SCAN_DIV-1.
//    * At pc = SCAN_DIV-1, col_idx advances, wrapping 6 -> 0.
//  - Frame: 7 slots = 7*SCAN_DIV cycles.
//    * Last cycle of frame: col_idx = 6 and pc = SCAN_DIV-1.
//  - frame_start = (col_idx == 0) && (pc == 0).
//    * It is asserted in the first cycle after reset release.
//    * On frame_start, mode <= synchronised switches; mode is constant within a frame.
//  - col_n is all ones when pc == 0 (dead time) or when blanked.
//    * Otherwise col_n = ~(7'b1000000 >> col_idx).
//    * Outputs are decoded from registered state with no extra latency.
//  - Frame counter fc runs 0..STEP_FRAMES-1 and advances in the last cycle of each frame.
//    * A step occurs in the cycle where fc == STEP_FRAMES-1 and the frame ends.
//  - On a step, by mode:
//    * 00 static: no strobe; offset held.
//    * 01 scroll left: shift_l = 1 for that cycle; offset <= offset+1 mod MSG_LEN.
//    * 10 scroll right: shift_r = 1 for that cycle; offset <= offset-1 mod MSG_LEN.
//    * 11 blink: the blink phase bit toggles; offset held; no strobe.
//  - Blanking: col_n is forced to all ones while mode == 11 and the phase bit = 1.
//    * Leaving mode 11 clears the phase bit at that frame_start.
//  - Simultaneous events:
//    * A step and frame_start never coincide; a step is in the last cycle of a frame.
//    * A switch change is seen only at the next frame_start.
//    * A step always uses the mode latched for the current frame.
//  - shift_l and shift_r are never high together.
//    * Each strobe is exactly 1 cycle long, once per step.
// TESTING  (SCAN_DIV=4, STEP_FRAMES=2, MSG_LEN=16)
//  1. Reset, then release -> col_n = 7F; then 0111111 in cycles 1-3; 7F in cycle 4;
//     1011111 in cycles 5-7; frame_start at cycles 0, 28, 56.
//  2. ch = 01 held -> mode = 01 from frame_start at cycle 28; shift_l in cycle 55 of
//     each 56-cycle step; offset 0 -> 1; after 16 steps it wraps 15 -> 0.
//  3. ch = 10 from offset 0 -> shift_r strobe; offset 15, then 14; shift_l stays 0.
//  4. ch changes 01 -> 10 during column 3 of a frame -> mode changes only at the next
//     frame_start; a step ending that frame still uses 01 (shift_l).
//  5. ch = 11 -> col_n stays 7F for the whole 2-frame period after each alternate step;
//     offset is constant; no strobes. ch -> 00 restores scanning at the next frame.
//  6. rst pulsed during column 4 with offset = 5 -> same cycle: col_n = 7F, offset = 0,
//     strobes 0; after release the scan restarts at column 0 with frame_start.

Source files
------------

// File: rtl/matrix_scan_ctrl_if.sv
// rtl/matrix_scan_ctrl_if.sv - switch inputs and column/scroll outputs of the matrix scan sequencer
interface matrix_scan_ctrl_if #(
  parameter int MSG_LEN = 16
);
  localparam int OW = $clog2(MSG_LEN);

  logic          ch1;
  logic          ch0;
  logic [6:0]    col_n;
  logic [2:0]    col_idx;
  logic [OW-1:0] offset;
  logic          shift_l;
  logic          shift_r;
  logic          frame_start;
  logic [1:0]    mode;

  // Sequencer side: reads switches, drives column pins and row-register strobes
  modport master (
    input  ch1, ch0,
    output col_n, col_idx, offset, shift_l, shift_r, frame_start, mode
  );

  // Board side: drives switches, consumes column enables and strobes
  modport slave (
    output ch1, ch0,
    input  col_n, col_idx, offset, shift_l, shift_r, frame_start, mode
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - 5x7 LED matrix column scan and scroll/blink sequencer
module matrix_scan_ctrl #(
  parameter int SCAN_DIV    = 4,
  parameter int STEP_FRAMES = 2,
  parameter int MSG_LEN     = 16
) (
  input  logic                clk,
  input  logic                rst,
  matrix_scan_ctrl_if.master  scan
);
  localparam int OW = $clog2(MSG_LEN);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [PW-1:0] PC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(STEP_FRAMES - 1);
  localparam logic [2:0]    COL_LAST = 3'd6;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  logic [PW-1:0] pc_q, pc_d;
  logic [2:0]    col_q, col_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [1:0]    mode_q, mode_d;
  logic          phase_q, phase_d;
  logic [1:0]    sync1_q, sync2_q;

  logic slot_end;
  logic frame_first;
  logic frame_last;
  logic step;
  logic blanked;

  // Frame timing events derived directly from the registered counters
  assign slot_end    = (pc_q == PC_LAST);
  assign frame_first = (col_q == 3'd0) && (pc_q == '0);
  assign frame_last  = (col_q == COL_LAST) && slot_end;
  assign step        = frame_last && (fc_q == FC_LAST);
  assign blanked     = (mode_q == MODE_BLINK) && phase_q;

  // State register: switch synchroniser plus scan, frame, scroll and mode state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      pc_q     <= '0;
      col_q    <= 3'd0;
      fc_q     <= '0;
      offset_q <= '0;
      mode_q   <= MODE_STATIC;
      phase_q  <= 1'b0;
    end else begin
      sync1_q  <= {scan.ch1, scan.ch0};
      sync2_q  <= sync1_q;
      pc_q     <= pc_d;
      col_q    <= col_d;
      fc_q     <= fc_d;
      offset_q <= offset_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
    end
  end

  // Next state: prescaler/column/frame counting, step actions, per-frame mode latch
  always_comb begin
    pc_d     = slot_end ? '0 : pc_q + 1'b1;
    col_d    = col_q;
    fc_d     = fc_q;
    offset_d = offset_q;
    mode_d   = mode_q;
    phase_d  = phase_q;

    if (slot_end) begin
      col_d = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
    end

    if (frame_last) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end

    // A step sits in the last cycle of a frame, so it always acts on the
    // mode latched at that frame's start, never on a freshly latched one.
    if (step) begin
      case (mode_q)
        MODE_LEFT:  offset_d = offset_q + 1'b1;
        MODE_RIGHT: offset_d = offset_q - 1'b1;
        MODE_BLINK: phase_d  = ~phase_q;
        default:    offset_d = offset_q;
      endcase
    end

    // Switches are only honoured at frame boundaries; dropping out of blink
    // clears the phase so a later return to blink starts visible.
    if (frame_first) begin
      mode_d = sync2_q;
      if (sync2_q != MODE_BLINK) begin
        phase_d = 1'b0;
      end
    end
  end

  // Output decode from registered state: column enables with dead time and blanking, strobes
  always_comb begin
    scan.col_n       = 7'h7F;
    scan.col_idx     = col_q;
    scan.offset      = offset_q;
    scan.mode        = mode_q;
    scan.frame_start = frame_first;
    scan.shift_l     = step && (mode_q == MODE_LEFT);
    scan.shift_r     = step && (mode_q == MODE_RIGHT);
    if ((pc_q != '0) && !blanked) begin
      scan.col_n = ~(7'b1000000 >> col_q);
    end
  end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - self-checking bench for matrix_scan_ctrl
module tb_matrix_scan_ctrl;
  localparam int SD = 4;
  localparam int SF = 2;
  localparam int ML = 16;
  localparam int FRAME = 7 * SD;
  localparam int STEP = FRAME * SF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matrix_scan_ctrl_if #(.MSG_LEN(ML)) bus ();

  matrix_scan_ctrl #(
    .SCAN_DIV(SD),
    .STEP_FRAMES(SF),
    .MSG_LEN(ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan(bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int t = 0;
  int m_mode = 0;
  int m_offset = 0;
  int m_phase = 0;
  logic [1:0] hist [0:4095];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  task automatic set_ch(input logic [1:0] v);
    bus.ch1 = v[1];
    bus.ch0 = v[0];
  endtask

  task automatic model_reset();
    t = 0;
    m_mode = 0;
    m_offset = 0;
    m_phase = 0;
  endtask

  // Sample cycle t at the falling edge, compare against the model, then advance the model.
  task automatic one_cycle();
    int pc, col, fs, stp;
    logic [6:0] e_col;
    @(negedge clk);
    hist[t] = {bus.ch1, bus.ch0};
    pc  = t % SD;
    col = (t / SD) % 7;
    fs  = (t % FRAME == 0) ? 1 : 0;
    stp = (t % STEP == STEP - 1) ? 1 : 0;
    e_col = 7'h7F;
    if (pc != 0 && !(m_mode == 3 && m_phase == 1)) e_col[6 - col] = 1'b0;
    chk("col_n", int'(bus.col_n), int'(e_col));
    chk("col_idx", int'(bus.col_idx), col);
    chk("offset", int'(bus.offset), m_offset);
    chk("mode", int'(bus.mode), m_mode);
    chk("frame_start", int'(bus.frame_start), fs);
    chk("shift_l", int'(bus.shift_l), (stp == 1 && m_mode == 1) ? 1 : 0);
    chk("shift_r", int'(bus.shift_r), (stp == 1 && m_mode == 2) ? 1 : 0);
    if (stp == 1) begin
      if (m_mode == 1) m_offset = (m_offset + 1) % ML;
      else if (m_mode == 2) m_offset = (m_offset + ML - 1) % ML;
      else if (m_mode == 3) m_phase = 1 - m_phase;
    end
    if (fs == 1) begin
      m_mode = (t >= 2) ? int'(hist[t - 2]) : 0;
      if (m_mode != 3) m_phase = 0;
    end
    t++;
  endtask

  task automatic run_to(input int last);
    while (t <= last) one_cycle();
  endtask

  initial begin
    set_ch(2'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_n", int'(bus.col_n), 'h7F);
    chk("rst_offset", int'(bus.offset), 0);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_strobes", int'({bus.shift_l, bus.shift_r}), 0);
    rst = 1'b0;
    model_reset();

    // Scan pattern after release and first mode latch
    run_to(0);  chk("c0_col_n", int'(bus.col_n), 'h7F);
                chk("c0_fs", int'(bus.frame_start), 1);
    run_to(1);  chk("c1_col_n", int'(bus.col_n), 'h3F);
    run_to(4);  chk("c4_col_n", int'(bus.col_n), 'h7F);
    run_to(5);  chk("c5_col_n", int'(bus.col_n), 'h5F);
    run_to(28); chk("c28_fs", int'(bus.frame_start), 1);
    run_to(29); chk("c29_mode", int'(bus.mode), 1);
    run_to(55); chk("c55_shift_l", int'(bus.shift_l), 1);
                chk("c55_offset", int'(bus.offset), 0);
    run_to(56); chk("c56_offset", int'(bus.offset), 1);

    // Switch change in column 3; the step closing that frame still scrolls left
    run_to(880); chk("c880_col", int'(bus.col_idx), 3);
    set_ch(2'b10);
    run_to(890); chk("c890_mode", int'(bus.mode), 1);
    run_to(895); chk("c895_offset", int'(bus.offset), 15);
                 chk("c895_shift_l", int'(bus.shift_l), 1);
    run_to(896); chk("c896_offset", int'(bus.offset), 0);
    run_to(897); chk("c897_mode", int'(bus.mode), 2);
    run_to(951); chk("c951_shift_r", int'(bus.shift_r), 1);
                 chk("c951_shift_l", int'(bus.shift_l), 0);
    run_to(952); chk("c952_offset", int'(bus.offset), 15);
    run_to(1008); chk("c1008_offset", int'(bus.offset), 14);

    // Blink: alternate step periods blanked, then back to static
    set_ch(2'b11);
    run_to(1065); chk("c1065_blank", int'(bus.col_n), 'h7F);
    run_to(1121); chk("c1121_col_n", int'(bus.col_n), 'h3F);
    run_to(1180); chk("c1180_blank", int'(bus.col_n), 'h7F);
    set_ch(2'b00);
    run_to(1201); chk("c1201_blank", int'(bus.col_n), 'h7F);
                  chk("c1201_offset", int'(bus.offset), 14);
    run_to(1205); chk("c1205_col_n", int'(bus.col_n), 'h3F);
                  chk("c1205_mode", int'(bus.mode), 0);

    // Scroll to offset 5, then reset in column 4
    set_ch(2'b01);
    run_to(1641); chk("c1641_offset", int'(bus.offset), 5);
                  chk("c1641_col", int'(bus.col_idx), 4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_col_n", int'(bus.col_n), 'h7F);
    chk("mid_rst_offset", int'(bus.offset), 0);
    chk("mid_rst_strobes", int'({bus.shift_l, bus.shift_r}), 0);
    chk("mid_rst_col", int'(bus.col_idx), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    run_to(0);  chk("r0_fs", int'(bus.frame_start), 1);
    run_to(55); chk("r55_shift_l", int'(bus.shift_l), 1);
    run_to(56); chk("r56_offset", int'(bus.offset), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
